// File: rtl/wave_gen.sv
// Programmable waveform generator: saw-up, saw-down, triangle and square
// samples stepped by a prescaler. Mode and step period are latched only at period boundaries.
module wave_gen #(
    parameter int CTR_BITS = 20,
    parameter int VAL_BITS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic [1:0]          mode,
    input  logic [CTR_BITS-1:0] div,
    output logic [VAL_BITS-1:0] val,
    output logic                wrap
);

    typedef enum logic [1:0] {
        SAW_UP = 2'b00,
        SAW_DN = 2'b01,
        TRI    = 2'b10,
        SQR    = 2'b11
    } mode_t;

    localparam logic [VAL_BITS-1:0] MAX = '1;
    localparam logic [VAL_BITS-1:0] ONE = VAL_BITS'(1);

    logic [CTR_BITS-1:0] ctr;
    logic [CTR_BITS-1:0] div_q;
    mode_t               mode_q;
    logic [VAL_BITS-1:0] p;
    logic                dir_down;

    logic                tick;
    logic                bound;
    logic [VAL_BITS-1:0] p_nx;
    logic [VAL_BITS-1:0] val_nx;
    logic                dir_nx;
    logic [VAL_BITS-1:0] start_val;

    // Next sample for the currently latched mode, and whether that step closes the period.
    always_comb begin
        tick   = en && !clr && (ctr == div_q);
        p_nx   = p;
        val_nx = val;
        dir_nx = dir_down;
        bound  = 1'b0;
        case (mode_q)
            SAW_UP: begin
                p_nx   = p + ONE;
                val_nx = p_nx;
                bound  = (p_nx == '0);
            end
            SAW_DN: begin
                val_nx = val - ONE;
                bound  = (val_nx == MAX);
            end
            TRI: begin
                if (!dir_down) begin
                    val_nx = val + ONE;
                    dir_nx = (val_nx == MAX);
                end else begin
                    val_nx = val - ONE;
                    bound  = (val_nx == '0);
                end
            end
            default: begin
                p_nx   = p + ONE;
                val_nx = p_nx[VAL_BITS-1] ? MAX : '0;
                bound  = (p_nx == '0);
            end
        endcase
        // Start value depends on the mode being latched, not the one ending.
        start_val = (mode_t'(mode) == SAW_DN) ? MAX : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr      <= '0;
            div_q    <= '0;
            mode_q   <= SAW_UP;
            p        <= '0;
            dir_down <= 1'b0;
            val      <= '0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr || (tick && bound)) begin
                ctr      <= '0;
                mode_q   <= mode_t'(mode);
                div_q    <= div;
                p        <= '0;
                dir_down <= 1'b0;
                val      <= start_val;
                wrap     <= 1'b1;
            end else if (tick) begin
                ctr      <= '0;
                p        <= p_nx;
                val      <= val_nx;
                dir_down <= dir_nx;
            end else if (en) begin
                ctr <= ctr + CTR_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: a period/phase-index model checked every cycle, plus directed
// literal checks on a 3-bit instance and a 1-bit instance.
module tb_wave_gen;

    localparam int CB  = 8;
    localparam int VB  = 3;
    localparam int MAX = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic [1:0]    mode;
    logic [CB-1:0] div;
    logic [VB-1:0] val;
    logic          wrap;
    logic [0:0]    val1;
    logic          wrap1;

    int checks = 0;
    int errors = 0;

    wave_gen #(.CTR_BITS(CB), .VAL_BITS(VB)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .div(div),
        .val(val), .wrap(wrap)
    );

    wave_gen #(.CTR_BITS(CB), .VAL_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .div(div),
        .val(val1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a waveform is a function of (mode, tick index k within the period).
    function automatic int period(input int m);
        return (m == 2) ? 2 * MAX : MAX + 1;
    endfunction

    function automatic int shape(input int m, input int k);
        case (m)
            0:       return k;
            1:       return MAX - k;
            2:       return (k <= MAX) ? k : 2 * MAX - k;
            default: return (k >= (MAX + 1) / 2) ? MAX : 0;
        endcase
    endfunction

    int m_mode = 0;
    int m_div  = 0;
    int m_cnt  = 0;
    int m_k    = 0;
    int m_wrap = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_div <= 0; m_cnt <= 0; m_k <= 0; m_wrap <= 0;
        end else begin
            m_wrap <= 0;
            if (clr) begin
                m_mode <= int'(mode); m_div <= int'(div);
                m_cnt <= 0; m_k <= 0; m_wrap <= 1;
            end else if (en) begin
                if (m_cnt == m_div) begin
                    m_cnt <= 0;
                    if (m_k + 1 == period(m_mode)) begin
                        m_k <= 0; m_mode <= int'(mode); m_div <= int'(div); m_wrap <= 1;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_val", int'(val), shape(m_mode, m_k));
        check("model_wrap", int'(wrap), m_wrap);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        rst = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00; div = '0;
        #1 rst = 1'b1;
        cyc(2);
        check("reset_val", int'(val), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_val1", int'(val1), 0);

        // Out of reset: saw-up, tick every cycle
        rst = 1'b0; en = 1'b1;
        cyc; check("post_rst_v1", int'(val), 1); check("post_rst_w", int'(wrap), 0);
        cyc; check("post_rst_v2", int'(val), 2);

        // Saw-up, div=1: each value held two cycles
        clr = 1'b1; mode = 2'b00; div = 8'd1;
        cyc; clr = 1'b0;
        check("saw_v0", int'(val), 0); check("saw_w0", int'(wrap), 1);
        for (int i = 1; i < 18; i++) begin
            cyc;
            check("saw_val", int'(val), (i / 2) % 8);
            check("saw_wrap", int'(wrap), (i == 16) ? 1 : 0);
        end

        // Freeze with en low mid-ramp
        cyc(5);
        v = int'(val);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc;
            check("hold_val", int'(val), v);
            check("hold_wrap", int'(wrap), 0);
        end
        en = 1'b1;
        cyc(6);

        // Triangle, div=0
        clr = 1'b1; mode = 2'b10; div = 8'd0;
        cyc; clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) cyc;
            check("tri_val", int'(val), (i % 14 <= 7) ? i % 14 : 14 - i % 14);
            check("tri_wrap", int'(wrap), (i % 14 == 0) ? 1 : 0);
        end

        // Square, div=0
        clr = 1'b1; mode = 2'b11; div = 8'd0;
        cyc; clr = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) cyc;
            check("sq_val", int'(val), (i % 8 >= 4) ? 7 : 0);
            check("sq_wrap", int'(wrap), (i % 8 == 0) ? 1 : 0);
        end

        // Saw-down, then mode/div change mid-period
        clr = 1'b1; mode = 2'b01; div = 8'd0;
        cyc; clr = 1'b0;
        check("sd_v0", int'(val), 7); check("sd_w0", int'(wrap), 1);
        cyc(3);
        check("sd_v3", int'(val), 4);
        mode = 2'b00; div = 8'd3;
        for (int i = 4; i < 8; i++) begin
            cyc;
            check("sd_val", int'(val), 7 - i);
            check("sd_wrap", int'(wrap), 0);
        end
        for (int j = 0; j < 9; j++) begin
            cyc;
            check("sd2su_val", int'(val), j / 4);
            check("sd2su_wrap", int'(wrap), (j == 0) ? 1 : 0);
        end

        // Asynchronous reset mid-triangle
        clr = 1'b1; mode = 2'b10; div = 8'd0;
        cyc; clr = 1'b0;
        cyc(5);
        check("tri_pre_rst", int'(val), 5);
        #3 rst = 1'b1;
        #1;
        check("async_val", int'(val), 0);
        check("async_wrap", int'(wrap), 0);
        clr = 1'b1; mode = 2'b11; div = 8'd5;
        cyc(2);
        check("rst_hold_val", int'(val), 0);
        check("rst_hold_wrap", int'(wrap), 0);
        rst = 1'b0; clr = 1'b0; mode = 2'b00; div = 8'd0;
        cyc;
        check("rel_val", int'(val), 1); check("rel_wrap", int'(wrap), 0);
        cyc;
        check("rel_val2", int'(val), 2);

        // One-bit sample width, all modes
        for (int m = 0; m < 4; m++) begin
            clr = 1'b1; mode = 2'(m); div = 8'd0;
            cyc; clr = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (i > 0) cyc;
                check("w1_val", int'(val1), (m == 1) ? 1 - i % 2 : i % 2);
                check("w1_wrap", int'(wrap1), (i % 2 == 0) ? 1 : 0);
            end
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
